// File: rtl/npc_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, reset PC and PC alignment helpers.
// Used by ifu_fetch and its bus interface.
package npc_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;

    // Instructions are word aligned; low two bits of any PC must be zero.
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [2:0] {
        REQ   = 3'd0,
        WAIT  = 3'd1,
        HOLD  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } fetch_state_e;

    function automatic logic pc_misaligned(input logic [XLEN-1:0] addr);
        return (addr & ~PC_ALIGN_MASK) != '0;
    endfunction

    function automatic logic [XLEN-1:0] pc_align(input logic [XLEN-1:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Bundle of the fetch unit's memory, decode and PC-redirect signals.
// master = fetch unit side, slave = memory/decode/execute environment side.
interface ifu_fetch_if;
  import npc_pkg::*;

  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-1:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [XLEN-1:0] mem_rsp_data;
  logic            mem_rsp_err;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] pc;
  logic            ifu_valid;
  logic            idu_ready;
  logic            next_pc_valid;
  logic [XLEN-1:0] next_pc;
  logic            fetch_fault;

  modport master (
    output mem_req_valid, mem_req_addr, inst, pc, ifu_valid, fetch_fault,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
           idu_ready, next_pc_valid, next_pc
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, inst, pc, ifu_valid, fetch_fault,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data, mem_rsp_err,
           idu_ready, next_pc_valid, next_pc
  );

endinterface

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch unit: one instruction in flight, REQ->WAIT->HOLD->DONE.
// Define IFU_MISALIGN_TRAP_EN to fault on a misaligned redirect instead of masking bits [1:0].
module ifu_fetch
  import npc_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  ifu_fetch_if.master bus
);

  fetch_state_e    state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [XLEN-1:0] inst_reg, inst_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= REQ;
      pc_reg    <= RESET_PC;
      inst_reg  <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      inst_reg  <= inst_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    inst_next  = inst_reg;
    case (state_reg)
      REQ: begin
        if (bus.mem_req_ready)
          state_next = WAIT;
      end
      // Responses are only looked at here, so one landing on the accept cycle is dropped.
      WAIT: begin
        if (bus.mem_rsp_valid) begin
          if (bus.mem_rsp_err) begin
            state_next = FAULT;
          end else begin
            inst_next  = bus.mem_rsp_data;
            state_next = HOLD;
          end
        end
      end
      HOLD: begin
        if (bus.idu_ready)
          state_next = DONE;
      end
      DONE: begin
        if (bus.next_pc_valid) begin
`ifdef IFU_MISALIGN_TRAP_EN
          if (pc_misaligned(bus.next_pc)) begin
            state_next = FAULT;
          end else begin
            pc_next    = bus.next_pc;
            state_next = REQ;
          end
`else
          pc_next    = pc_align(bus.next_pc);
          state_next = REQ;
`endif
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = FAULT;
      end
    endcase
  end

  assign bus.mem_req_valid = (state_reg == REQ);
  assign bus.mem_req_addr  = pc_reg;
  assign bus.pc            = pc_reg;
  assign bus.inst          = inst_reg;
  assign bus.ifu_valid     = (state_reg == HOLD);
  assign bus.fetch_fault   = (state_reg == FAULT);

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h8000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 mem_req_valid  out  1  fetch request to instruction memory.
REQ-005 mem_req_ready  in  1  memory accepts request.
REQ-006 mem_req_addr  out  32  fetch address; equals pc.
REQ-007 mem_rsp_valid  in  1  read data returned; one-cycle pulse.
REQ-008 mem_rsp_data  in  32  instruction word.
REQ-009 mem_rsp_err  in  1  bus error; qualified by mem_rsp_valid.
REQ-010 inst  out  32  instruction presented to decode.
REQ-011 pc  out  32  address of inst / current fetch.
REQ-012 ifu_valid  out  1  inst valid toward decode.
REQ-013 idu_ready  in  1  decode accepts inst.
REQ-014 next_pc_valid  in  1  execute/writeback commits next PC; one-cycle pulse.
REQ-015 next_pc  in  32  next PC (pc+4, branch or jalr target).
REQ-016 fetch_fault  out  1  sticky fault flag; fetch halted.

Function
REQ-017 FSM states SHALL be REQ, WAIT, HOLD, DONE, FAULT.
REQ-018 REQ: mem_req_valid=1; on mem_req_ready go WAIT; mem_req_addr stable while unaccepted.
REQ-019 WAIT: on mem_rsp_valid&&!mem_rsp_err latch mem_rsp_data into inst, go HOLD; with mem_rsp_err go FAULT.
REQ-020 A response arriving in the same cycle as request acceptance SHALL be ignored (minimum one cycle REQ->HOLD latency through WAIT).
REQ-021 HOLD: ifu_valid=1; inst and pc stable until transfer; transfer when ifu_valid&&idu_ready, then go DONE.
REQ-022 DONE: ifu_valid=0; on next_pc_valid load pc<=next_pc and go REQ.
REQ-023 next_pc_valid outside DONE SHALL be ignored; exactly one instruction in flight (non-pipelined).
REQ-024 FAULT: all outputs idle except fetch_fault=1; exit only by reset.
REQ-025 ifu_valid SHALL never be asserted in REQ, WAIT, DONE or FAULT.
REQ-026 pc arithmetic 32-bit unsigned; next_pc 32'hFFFF_FFFC followed by 0 wraps with no special handling.

Reset
REQ-027 Reset SHALL give state=REQ, pc=RESET_PC, inst=0, ifu_valid=0, fetch_fault=0; mem_req_valid=1 from the first cycle after rst deasserts.
REQ-028 Reset asserted mid-transaction SHALL abandon it; instruction memory shares rst, so no stale response exists.

Configuration
REQ-029 With IFU_MISALIGN_TRAP_EN defined, next_pc[1:0]!=0 accepted in DONE SHALL go FAULT with no memory request; without it, bits [1:0] SHALL be forced to 0 and fetch proceeds.

Structure
REQ-030 FSM state encoding and RESET_PC default SHALL live in shared package npc_pkg.
REQ-031 No sub-module; single flat module.

Verification
REQ-032 Reset release, mem_req_ready=1, response 32'h00000413 next cycle -> mem_req_addr=32'h8000_0000, ifu_valid=1 with inst=32'h00000413 two cycles after reset release.
REQ-033 idu_ready held 0 for 5 cycles in HOLD -> ifu_valid, inst and pc constant; transfer on the cycle idu_ready=1; ifu_valid=0 next cycle.
REQ-034 next_pc_valid with next_pc=32'h8000_0100 in DONE -> next mem_req_addr=32'h8000_0100; same pulse during WAIT -> ignored, pc unchanged.
REQ-035 mem_req_ready low 3 cycles -> mem_req_valid held, addr stable; mem_rsp_err=1 in WAIT -> fetch_fault=1, no further requests.
REQ-036 next_pc=32'h8000_0102: macro defined -> fetch_fault=1, no request; undefined -> mem_req_addr=32'h8000_0100.
REQ-037 rst pulsed while in WAIT -> state REQ, pc=RESET_PC, ifu_valid=0 asynchronously.
